// File: rtl/bram_arbiter_pkg.sv
// Shared types and constants for the two-requester BRAM arbiter.
// Optional alignment checking is enabled by defining BRAM_ARB_ALIGN_CHK_EN.
package bram_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic [3:0] W_REQ_ALL  = 4'b1111;
    localparam logic [3:0] W_REQ_NONE = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

endpackage

// File: rtl/bram_arb_mux.sv
// Combinational steering of the owning requester onto the BRAM pins.
// Address/data follow the grant; the access strobes follow the issue qualifier.
module bram_arb_mux
    import bram_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              i_sel,
    input  logic              i_gnt,
    input  logic              i_issue,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_r_req,
    output logic [ADDR_W-1:0] o_addr,
    output logic [3:0]        o_w_req,
    output logic [DATA_W-1:0] o_w_data
);

    always_comb begin
        o_r_req  = 1'b0;
        o_addr   = '0;
        o_w_req  = W_REQ_NONE;
        o_w_data = '0;
        if (i_gnt) begin
            o_addr   = i_sel ? i_addr1  : i_addr0;
            o_w_data = i_sel ? i_wdata1 : i_wdata0;
        end
        if (i_issue) begin
            o_r_req = 1'b1;
            o_w_req = (i_sel ? i_we1 : i_we0) ? W_REQ_ALL : W_REQ_NONE;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin burst arbiter sharing one single-port BRAM between loader and compute.
// Define BRAM_ARB_ALIGN_CHK_EN to reject misaligned beats and report them on err0/err1.
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              R_req,
    output logic [ADDR_W-1:0] addr,
    output logic [3:0]        W_req,
    output logic [DATA_W-1:0] W_data,
    input  logic [DATA_W-1:0] R_data
`ifdef BRAM_ARB_ALIGN_CHK_EN
    ,
    output logic              err0,
    output logic              err1
`endif
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_rr;
    logic              w_rr_nxt;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic              w_sel;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_gnt;
    logic              w_issue;
    logic              w_own_req;
    logic              w_oth_req;
    logic              w_last;
    logic              w_sel_we;

    assign w_sel     = (r_state == ST_OWN1);
    assign w_gnt0    = (r_state == ST_OWN0) && req0;
    assign w_gnt1    = (r_state == ST_OWN1) && req1;
    assign w_gnt     = w_gnt0 || w_gnt1;
    assign w_own_req = w_sel ? req1 : req0;
    assign w_oth_req = w_sel ? req0 : req1;
    assign w_sel_we  = w_sel ? we1 : we0;
    assign w_last    = w_gnt && (r_cnt == CNT_W'(MAX_BEATS - 1));

`ifdef BRAM_ARB_ALIGN_CHK_EN
    logic w_misal;
    logic r_err0;
    logic r_err1;

    // Misaligned beats are still granted and counted, but never reach the BRAM.
    assign w_misal = (w_sel ? addr1[1:0] : addr0[1:0]) != 2'b00;
    assign w_issue = w_gnt && !w_misal;
    assign err0    = r_err0;
    assign err1    = r_err1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
        end else begin
            r_err0 <= w_gnt0 && w_misal;
            r_err1 <= w_gnt1 && w_misal;
        end
    end
`else
    assign w_issue = w_gnt;
`endif

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata   = R_data;

    bram_arb_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .i_sel    (w_sel),
        .i_gnt    (w_gnt),
        .i_issue  (w_issue),
        .i_we0    (we0),
        .i_addr0  (addr0),
        .i_wdata0 (wdata0),
        .i_we1    (we1),
        .i_addr1  (addr1),
        .i_wdata1 (wdata1),
        .o_r_req  (R_req),
        .o_addr   (addr),
        .o_w_req  (W_req),
        .o_w_data (W_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rr      <= 1'b1;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rr      <= w_rr_nxt;
            r_rvalid0 <= w_issue && !w_sel && !w_sel_we;
            r_rvalid1 <= w_issue && w_sel && !w_sel_we;
        end
    end

    // r_rr holds the last owner, so on a tie the other requester wins.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rr_nxt    = r_rr;
        unique case (r_state)
            ST_IDLE: begin
                if (req0 && (!req1 || r_rr)) begin
                    w_state_nxt = ST_OWN0;
                    w_cnt_nxt   = '0;
                    w_rr_nxt    = 1'b0;
                end else if (req1) begin
                    w_state_nxt = ST_OWN1;
                    w_cnt_nxt   = '0;
                    w_rr_nxt    = 1'b1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (w_gnt) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
                if (!w_own_req || w_last) begin
                    if (w_oth_req) begin
                        w_state_nxt = w_sel ? ST_OWN0 : ST_OWN1;
                        w_cnt_nxt   = '0;
                        w_rr_nxt    = !w_sel;
                    end else if (w_own_req) begin
                        w_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter: directed scenarios plus randomized two-requester traffic.
// Grants, pins and read data are predicted by a transaction-level model of the arbitration rules.
module tb_bram_arbiter;
    import bram_arbiter_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int MAXB  = 4;
    localparam int CW    = 5;
    localparam int WORDS = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, R_req;
    logic [DW-1:0] rdata, W_data, R_data;
    logic [AW-1:0] addr;
    logic [3:0]    W_req;
`ifdef BRAM_ARB_ALIGN_CHK_EN
    logic          err0, err1;
`endif

    bram_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_BEATS (MAXB),
        .CNT_W     (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .we0     (we0),
        .addr0   (addr0),
        .wdata0  (wdata0),
        .gnt0    (gnt0),
        .rvalid0 (rvalid0),
        .req1    (req1),
        .we1     (we1),
        .addr1   (addr1),
        .wdata1  (wdata1),
        .gnt1    (gnt1),
        .rvalid1 (rvalid1),
        .rdata   (rdata),
        .R_req   (R_req),
        .addr    (addr),
        .W_req   (W_req),
        .W_data  (W_data),
        .R_data  (R_data)
`ifdef BRAM_ARB_ALIGN_CHK_EN
        ,
        .err0    (err0),
        .err1    (err1)
`endif
    );

    always #5 clk = ~clk;

    // BRAM behaviour: registered read, full-word write, word index = byte address >> 2
    logic [DW-1:0] bram [WORDS];
    always @(posedge clk) begin
        if (R_req) begin
            if (W_req == 4'b1111) bram[addr[7:2]] <= W_data;
            else                  R_data <= bram[addr[7:2]];
        end
    end

    int nChecks = 0;
    int nErrors = 0;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;

    beat_t bq0[$];
    beat_t bq1[$];
    bit    took0 = 1'b0, took1 = 1'b0;
    bit    monOn = 1'b1;

    task automatic applyStimulus(input int r, input bit we, input int byteAddr, input logic [DW-1:0] d);
        beat_t b;
        b.we = we;
        b.a  = AW'(byteAddr);
        b.d  = d;
        if (r == 0) bq0.push_back(b);
        else        bq1.push_back(b);
    endtask

    // Requesters: present the head beat, retire it after a cycle in which it was granted
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (took0 && bq0.size() > 0) void'(bq0.pop_front());
            if (took1 && bq1.size() > 0) void'(bq1.pop_front());
            if (bq0.size() > 0) begin
                req0 = 1'b1; we0 = bq0[0].we; addr0 = bq0[0].a; wdata0 = bq0[0].d;
            end else begin
                req0 = 1'b0; we0 = 1'b0;
            end
            if (bq1.size() > 0) begin
                req1 = 1'b1; we1 = bq1[0].we; addr1 = bq1[0].a; wdata1 = bq1[0].d;
            end else begin
                req1 = 1'b0; we1 = 1'b0;
            end
        end
    end

    // Reference model: owner -1 = nobody, 0/1 = requester; lastOwner breaks ties
    int            mOwner = -1;
    int            mLast  = 1;
    int            mBeats = 0;
    bit            mRv0 = 1'b0, mRv1 = 1'b0;
    bit            eg0, eg1, mine, other;
    logic [DW-1:0] refMem [WORDS];
    logic [DW-1:0] rq0[$];
    logic [DW-1:0] rq1[$];
    logic [DW-1:0] expRd;

    always @(negedge clk) begin
        took0 = gnt0;
        took1 = gnt1;
        if (!rst) begin
            mOwner = -1; mLast = 1; mBeats = 0;
            mRv0 = 1'b0; mRv1 = 1'b0;
            rq0.delete(); rq1.delete();
        end else if (monOn) begin
            eg0 = (mOwner == 0) && req0;
            eg1 = (mOwner == 1) && req1;
            checkOutput("gnt0", DW'(gnt0), DW'(eg0));
            checkOutput("gnt1", DW'(gnt1), DW'(eg1));
            checkOutput("rvalid0", DW'(rvalid0), DW'(mRv0));
            checkOutput("rvalid1", DW'(rvalid1), DW'(mRv1));
            checkOutput("R_req", DW'(R_req), DW'(eg0 || eg1));
            if (eg0) begin
                checkOutput("addr0", addr, addr0);
                checkOutput("W_req0", DW'(W_req), we0 ? 32'hF : 32'h0);
                if (we0) checkOutput("W_data0", W_data, wdata0);
            end else if (eg1) begin
                checkOutput("addr1", addr, addr1);
                checkOutput("W_req1", DW'(W_req), we1 ? 32'hF : 32'h0);
                if (we1) checkOutput("W_data1", W_data, wdata1);
            end else begin
                checkOutput("W_req_idle", DW'(W_req), 32'h0);
                if (mOwner < 0) checkOutput("addr_idle", addr, '0);
            end
            if (rvalid0) begin
                if (rq0.size() > 0) begin
                    expRd = rq0.pop_front();
                    checkOutput("rdata0", rdata, expRd);
                end else checkOutput("rvalid0_unexpected", 32'h1, 32'h0);
            end
            if (rvalid1) begin
                if (rq1.size() > 0) begin
                    expRd = rq1.pop_front();
                    checkOutput("rdata1", rdata, expRd);
                end else checkOutput("rvalid1_unexpected", 32'h1, 32'h0);
            end
            mRv0 = eg0 && !we0;
            mRv1 = eg1 && !we1;
            if (eg0) begin
                if (we0) refMem[addr0[7:2]] = wdata0;
                else     rq0.push_back(refMem[addr0[7:2]]);
            end
            if (eg1) begin
                if (we1) refMem[addr1[7:2]] = wdata1;
                else     rq1.push_back(refMem[addr1[7:2]]);
            end
            if (mOwner < 0) begin
                if (req0 && req1) mOwner = 1 - mLast;
                else if (req0)    mOwner = 0;
                else if (req1)    mOwner = 1;
                if (mOwner >= 0) begin
                    mLast  = mOwner;
                    mBeats = 0;
                end
            end else begin
                mine  = (mOwner == 0) ? req0 : req1;
                other = (mOwner == 0) ? req1 : req0;
                if (mine) mBeats++;
                if (!mine || mBeats == MAXB) begin
                    if (other) begin
                        mOwner = 1 - mOwner;
                        mLast  = mOwner;
                        mBeats = 0;
                    end else if (mine) begin
                        mBeats = 0;
                    end else begin
                        mOwner = -1;
                    end
                end
            end
        end
    end

    task automatic waitDrain();
        int n = 0;
        while ((bq0.size() > 0 || bq1.size() > 0 || req0 || req1) && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) checkOutput("drainTimeout", 32'h1, 32'h0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_gnt0", DW'(gnt0), 32'h0);
        checkOutput("rst_gnt1", DW'(gnt1), 32'h0);
        checkOutput("rst_R_req", DW'(R_req), 32'h0);
        checkOutput("rst_rvalid0", DW'(rvalid0), 32'h0);
        checkOutput("rst_rvalid1", DW'(rvalid1), 32'h0);
`ifdef BRAM_ARB_ALIGN_CHK_EN
        checkOutput("rst_err0", DW'(err0), 32'h0);
`endif
        rst = 1'b1;

        applyStimulus(0, 1'b1, 'h0, 32'hA);
        applyStimulus(0, 1'b1, 'h4, 32'hB);
        applyStimulus(0, 1'b1, 'h8, 32'hC);
        waitDrain();
        checkOutput("bram_w0", bram[0], 32'hA);
        checkOutput("bram_w1", bram[1], 32'hB);
        checkOutput("bram_w2", bram[2], 32'hC);

        applyStimulus(1, 1'b0, 'h4, '0);
        waitDrain();

        for (int w = 3; w < WORDS; w++) applyStimulus(1, 1'b1, w * 4, $urandom);
        waitDrain();

        // Tie right after reset: requester 0 must win, then alternate in bursts
        rst = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1'b0, $urandom_range(0, WORDS - 1) * 4, '0);
            applyStimulus(1, 1'b0, $urandom_range(0, WORDS - 1) * 4, '0);
        end
        waitDrain();

        for (int i = 0; i < 20; i++) applyStimulus(1, 1'b0, i * 4, '0);
        waitDrain();

        for (int i = 0; i < 8; i++) applyStimulus(0, 1'b0, i * 4, '0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst_gnt0", DW'(gnt0), 32'h0);
        checkOutput("midrst_R_req", DW'(R_req), 32'h0);
        checkOutput("midrst_rvalid0", DW'(rvalid0), 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        waitDrain();

        for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 2) == 0 && bq0.size() < 6)
                applyStimulus(0, 1'($urandom_range(0, 1)), $urandom_range(0, WORDS - 1) * 4, $urandom);
            if ($urandom_range(0, 2) == 0 && bq1.size() < 6)
                applyStimulus(1, 1'($urandom_range(0, 1)), $urandom_range(0, WORDS - 1) * 4, $urandom);
        end
        waitDrain();
        checkOutput("rq0_empty", 32'(rq0.size()), 32'h0);
        checkOutput("rq1_empty", 32'(rq1.size()), 32'h0);

`ifdef BRAM_ARB_ALIGN_CHK_EN
        begin
            bit seen = 1'b0;
            monOn = 1'b0;
            applyStimulus(0, 1'b0, 'h6, '0);
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                if (gnt0) begin
                    seen = 1'b1;
                    checkOutput("mis_R_req", DW'(R_req), 32'h0);
                    checkOutput("mis_W_req", DW'(W_req), 32'h0);
                    @(negedge clk);
                    checkOutput("mis_err0", DW'(err0), 32'h1);
                    checkOutput("mis_rvalid0", DW'(rvalid0), 32'h0);
                end
            end
            checkOutput("mis_granted", DW'(seen), 32'h1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
